serial_cmp_ctrl: RTL and testbench

- Sequencer that performs an N-bit unsigned magnitude compare using a single 1-bit compare cell, evaluated once per clock, MSB first.
- Captures both operands on a start handshake and shifts them through the cell. Stops early at the first differing bit, or after all bits are equal.
- Reports registered g/l/e flags, the index of the deciding bit, and a one-cycle done pulse.
- Sits between a control FSM, which issues start, and the compare datapath. Trades area for latency versus a parallel N-bit comparator.

---
 rtl/serial_cmp_ctrl.sv | 103 ++++++++++
 tb/tb_serial_cmp_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/serial_cmp_ctrl.sv
// Bit-serial unsigned magnitude comparator: one 1-bit compare cell walks the
// captured operands MSB first and reports sticky g/l/e plus the deciding bit index.
module serial_cmp_ctrl #(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 1,
    localparam int IDX_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             g,
    output logic             l,
    output logic             e,
    output logic [IDX_W-1:0] diff_idx
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q, sb_q, sa_d, sb_d;
    logic [IDX_W-1:0] cnt_q, cnt_d, idx_q;
    logic             busy_q, done_q, g_q, l_q, e_q;
    logic             cell_g, cell_l, decided, take;

    always_comb begin
        cell_g  = sa_q[WIDTH-1] & ~sb_q[WIDTH-1];
        cell_l  = ~sa_q[WIDTH-1] & sb_q[WIDTH-1];
        decided = g_q | l_q;
        // Only the first differing bit may latch a decision.
        take    = ~decided & (cell_g | cell_l);
        sa_d    = sa_q << 1;
        sb_d    = sb_q << 1;
        cnt_d   = cnt_q - IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            g_q     <= 1'b0;
            l_q     <= 1'b0;
            e_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        cnt_q   <= IDX_W'(WIDTH - 1);
                        idx_q   <= '0;
                        g_q     <= 1'b0;
                        l_q     <= 1'b0;
                        e_q     <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (take) begin
                        g_q   <= cell_g;
                        l_q   <= cell_l;
                        idx_q <= cnt_q;
                    end
                    if (take && (EARLY_EXIT != 0)) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (cnt_q == '0) begin
                        if (!decided && !take) e_q <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        sa_q  <= sa_d;
                        sb_q  <= sb_d;
                        cnt_q <= cnt_d;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign g        = g_q;
    assign l        = l_q;
    assign e        = e_q;
    assign diff_idx = idx_q;

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Directed bench: one early-exit and one full-scan comparator driven with shared
// operands; timing and results checked against hand-computed values.
module tb_serial_cmp_ctrl;

    logic       clk = 1'b0;
    logic       rst0_n, rst1_n, start0, start1;
    logic [7:0] av, bv;
    logic       busy0, done0, g0, l0, e0;
    logic       busy1, done1, g1, l1, e1;
    logic [2:0] idx0, idx1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_cmp_ctrl #(.WIDTH(8), .EARLY_EXIT(1)) u0 (
        .clk(clk), .rst_n(rst0_n), .start(start0), .a(av), .b(bv),
        .busy(busy0), .done(done0), .g(g0), .l(l0), .e(e0), .diff_idx(idx0)
    );

    serial_cmp_ctrl #(.WIDTH(8), .EARLY_EXIT(0)) u1 (
        .clk(clk), .rst_n(rst1_n), .start(start1), .a(av), .b(bv),
        .busy(busy1), .done(done1), .g(g1), .l(l1), .e(e1), .diff_idx(idx1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch on both instances, watch 20 cycles, then check timing and held results.
    task automatic run_cmp(input string nm, input logic [7:0] a_v, input logic [7:0] b_v,
                           input logic eg, input logic el, input logic ee,
                           input logic [2:0] eidx, input int dc0, input int dc1);
        int n0, n1, d0, d1;
        n0 = 0; n1 = 0; d0 = -1; d1 = -1;
        av = a_v; bv = b_v; start0 = 1'b1; start1 = 1'b1;
        tick();
        start0 = 1'b0; start1 = 1'b0;
        chk({nm, " busy0@1"}, busy0, 1'b1);
        chk({nm, " busy1@1"}, busy1, 1'b1);
        for (int c = 1; c <= 20; c++) begin
            if (done0) begin n0++; d0 = c; end
            if (done1) begin n1++; d1 = c; end
            if (c == 1) begin av = ~a_v; bv = b_v ^ 8'h5A; end
            tick();
        end
        chk({nm, " ee1 done count"}, n0, 1);
        chk({nm, " ee1 done cycle"}, d0, dc0);
        chk({nm, " ee0 done count"}, n1, 1);
        chk({nm, " ee0 done cycle"}, d1, dc1);
        chk({nm, " ee1 gle"}, {g0, l0, e0}, {eg, el, ee});
        chk({nm, " ee1 idx"}, idx0, eidx);
        chk({nm, " ee0 gle"}, {g1, l1, e1}, {eg, el, ee});
        chk({nm, " ee0 idx"}, idx1, eidx);
        chk({nm, " ee1 busy end"}, busy0, 1'b0);
        chk({nm, " ee0 busy end"}, busy1, 1'b0);
    endtask

    initial begin
        int nd, dA, dB;
        logic [3:0] rA, rB;

        rst0_n = 1'b0; rst1_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
        av = 8'h00; bv = 8'h00;
        tick(); tick();
        rst0_n = 1'b1; rst1_n = 1'b1;
        tick();
        chk("reset ee1 outputs", {busy0, done0, g0, l0, e0, idx0}, 8'h00);
        chk("reset ee0 outputs", {busy1, done1, g1, l1, e1, idx1}, 8'h00);

        run_cmp("eq A5", 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1, 3'd0, 9, 9);
        run_cmp("80v7F", 8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 3'd7, 2, 9);
        run_cmp("12v13", 8'h12, 8'h13, 1'b0, 1'b1, 1'b0, 3'd0, 9, 9);
        run_cmp("F0v0F", 8'hF0, 8'h0F, 1'b1, 1'b0, 1'b0, 3'd7, 2, 9);

        // start held high: second compare accepted right after DONE.
        nd = 0; dA = -1; dB = -1; rA = '0; rB = '0;
        av = 8'h40; bv = 8'h20; start0 = 1'b1;
        tick();
        av = 8'h00; bv = 8'hFF;
        for (int c = 1; c <= 6; c++) begin
            if (done0) begin
                nd++;
                if (nd == 1) begin dA = c; rA = {g0, idx0}; end
                else begin dB = c; rB = {l0, idx0}; end
            end
            if (c == 6) start0 = 1'b0;
            tick();
        end
        for (int c = 0; c < 12; c++) begin
            if (done0) nd++;
            tick();
        end
        chk("held first done cycle", dA, 3);
        chk("held first g/idx", rA, {1'b1, 3'd6});
        chk("held second done cycle", dB, 6);
        chk("held second l/idx", rB, {1'b1, 3'd7});
        chk("held done count", nd, 2);

        // Reset in cycle 4 of an in-flight compare aborts it silently.
        av = 8'h01; bv = 8'h00; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick(); tick(); tick();
        rst0_n = 1'b0;
        tick();
        rst0_n = 1'b1;
        chk("abort outputs", {busy0, done0, g0, l0, e0, idx0}, 8'h00);
        nd = 0;
        for (int c = 0; c < 15; c++) begin
            if (done0) nd++;
            tick();
        end
        chk("abort no done", nd, 0);
        run_cmp("post-reset 01v00", 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 9, 9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
